muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 The block SHALL provide the following ports:
- clk_i  input  1  single clock, all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  request for a new M-extension operation; sampled only in IDLE.
- op_i  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  input  32  operand A (multiplicand/dividend), sampled with start_i.
- rs2_i  input  32  operand B (multiplier/divisor), sampled with start_i.
- flush_i  input  1  abort the in-flight operation.
- busy_o  output  1  high in CALC and FIX.
- stall_o  output  1  pipeline hold request to the issuing stage.
- valid_o  output  1  one-cycle result strobe.
- result_o  output  32  result; meaningful only while valid_o is high.

Function
REQ-003 The block SHALL implement the states IDLE, CALC, FIX and DONE, encoded in a single state register.
REQ-004 In IDLE with start_i=1 and flush_i=0 in cycle N, the block SHALL latch op_i, rs1_i and rs2_i, and take absolute values for signed operands:
- MULH: both operands signed.
- MULHSU: rs1 signed only.
- DIV/REM: both operands signed.
- MUL, MULHU, DIVU, REMU: operands treated as unsigned.
REQ-005 Normal path timing SHALL be:
- CALC occupies cycles N+1..N+32, driven by a 6-bit iteration counter that counts 0..31.
- FIX occupies cycle N+33.
- DONE occupies cycle N+34 with valid_o=1.
- The block SHALL return to IDLE at N+35.
REQ-006 In CALC, multiplication SHALL be shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
REQ-007 In CALC, division SHALL be restoring, one quotient bit per cycle, producing a 32-bit quotient and a 32-bit remainder.
REQ-008 In FIX, the block SHALL apply sign correction:
- Product is negated when the operand signs differ.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- Quotient truncates toward zero.
REQ-009 Result selection SHALL be:
- MUL: product[31:0].
- MULH, MULHSU, MULHU: product[63:32].
- DIV, DIVU: quotient.
- REM, REMU: remainder.
REQ-010 Division by zero SHALL bypass CALC and FIX and enter DONE at N+1:
- DIV/DIVU result = 0xFFFFFFFF.
- REM/REMU result = rs1.
REQ-011 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) SHALL enter DONE at N+1 with DIV result 0x80000000 and REM result 0.
REQ-012 stall_o SHALL be asserted in these cycles:
- Combinationally in IDLE while start_i=1 and flush_i=0.
- Throughout CALC and FIX.
- stall_o SHALL be 0 in DONE, so the issuing stage advances in the same cycle the result is valid.
REQ-013 The block SHALL ignore start_i in CALC, FIX and DONE; no request is queued.
REQ-014 flush_i=1 in any state SHALL force IDLE on the next edge and suppress valid_o.
REQ-015 flush_i=1 together with start_i=1 in IDLE SHALL NOT start an operation.
REQ-016 result_o SHALL hold its last value outside DONE.
REQ-017 Back-to-back operation SHALL be allowed: start_i is accepted in the IDLE cycle immediately following DONE.

Reset
REQ-018 While rst_ni=0, the block SHALL asynchronously force the following, independent of clk_i:
- State = IDLE, counter = 0, accumulator/quotient/remainder = 0.
- busy_o = 0, stall_o = 0, valid_o = 0, result_o = 0.
REQ-019 Reset asserted mid-operation SHALL discard the operation; after rst_ni rises, valid_o SHALL NOT pulse until a new start_i is accepted.
REQ-020 After reset release, the first rising edge with start_i=1 SHALL be accepted.

Verification
REQ-021 MUL rs1=7, rs2=0xFFFFFFFD at cycle N -> stall_o high N..N+33; valid_o only at N+34; result 0xFFFFFFEB.
REQ-022 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE at N+34.
REQ-023 MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-024 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at N+34; REM with the same operands -> 0xFFFFFFFF.
REQ-025 DIVU 5 / 0 -> 0xFFFFFFFF at N+1; REMU 5 / 0 -> 5 at N+1.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at N+1; REM with the same operands -> 0.
REQ-027 Flush and reset scenarios:
- DIVU 100/3 started at N, flush_i at N+10 -> no valid_o; IDLE at N+11; a new start at N+11 completes normally with 33 (DIVU) or 1 (REMU).
- rst_ni pulsed low at N+5 -> all outputs 0 immediately.
- start_i during CALC -> ignored, exactly one valid_o pulse.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide, 32 iterations)
module muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] result_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q, acc_d, prod;
  logic [31:0] opnd_q, result_q, a_abs, b_abs, spec_res, fix_res;
  logic [2:0]  op_q;
  logic        sa_q, neg_q, s1, s2, a_neg, b_neg, div0, ovf;
  logic [32:0] mul_sum, rem_sh, diff;
  always_comb begin
    s1 = op_i == 3'b001 || op_i == 3'b010 || op_i == 3'b100 || op_i == 3'b110;
    s2 = op_i == 3'b001 || op_i == 3'b100 || op_i == 3'b110;
    a_neg = s1 & rs1_i[31];
    b_neg = s2 & rs2_i[31];
    a_abs = a_neg ? -rs1_i : rs1_i;
    b_abs = b_neg ? -rs2_i : rs2_i;
    div0 = op_i[2] && rs2_i == 32'd0;
    ovf = op_i[2] && !op_i[0] && rs1_i == 32'h8000_0000 && rs2_i == 32'hFFFF_FFFF;
    spec_res = div0 ? (op_i[1] ? rs1_i : 32'hFFFF_FFFF) : (op_i[1] ? 32'd0 : 32'h8000_0000);
    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    rem_sh = acc_q[63:31];
    diff = rem_sh - {1'b0, opnd_q};
    acc_d = op_q[2] ? (diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1})
                    : {mul_sum, acc_q[31:1]};
    prod = neg_q ? -acc_q : acc_q;
    fix_res = op_q[2] ? (op_q[1] ? (sa_q ? -acc_q[63:32] : acc_q[63:32]) : (neg_q ? -acc_q[31:0] : acc_q[31:0]))
                      : (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      neg_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          op_q   <= op_i;
          opnd_q <= op_i[2] ? b_abs : a_abs;
          acc_q  <= {32'd0, op_i[2] ? a_abs : b_abs};
          sa_q   <= a_neg;
          neg_q  <= a_neg ^ b_neg;
          cnt_q  <= '0;
          if (div0 || ovf) begin
            result_q <= spec_res;
            state_q  <= DONE;
          end else state_q <= CALC;
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_res;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o   = state_q == CALC || state_q == FIX;
  assign valid_o  = state_q == DONE;
  assign stall_o  = rst_ni && (busy_o || (state_q == IDLE && start_i && !flush_i));
  assign result_o = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random RV32M checks against an arithmetic reference model
module tb_muldiv_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        busy, stall, valid;
  logic [31:0] result;
  int checks = 0, errors = 0;

  muldiv_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .flush_i(flush), .busy_o(busy), .stall_o(stall), .valid_o(valid), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] p;
    bit ov = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ov ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int poke, input string tag);
    logic [31:0] e = model(o, a, b);
    bit sp = o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    int lat = sp ? 1 : 34;
    int vcnt = 0;
    int vfirst = -1;
    logic [31:0] res = '0;
    bit sbad = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    #1 chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (valid) begin
        vcnt++;
        if (vfirst < 0) begin vfirst = k; res = result; end
      end
      if (stall !== (!sp && k <= 33) || busy !== (!sp && k <= 33)) sbad = 1;
      start = k == poke;
      if (k == poke) begin op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; end
    end
    chk({tag, "_latency"}, 32'(vfirst), 32'(lat));
    chk({tag, "_pulses"}, 32'(vcnt), 32'd1);
    chk({tag, "_result"}, res, e);
    chk({tag, "_stall_busy"}, {31'd0, sbad}, 32'd0);
    chk({tag, "_hold"}, result, e);
  endtask

  initial begin
    logic [31:0] pool [5] = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    int vseen;
    #1 chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 0, "mulhsu");
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div");
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem");
    run(3'd5, 32'd5, 32'd0, 0, "divu_z");
    run(3'd7, 32'd5, 32'd0, 0, "remu_z");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    // flush in CALC at N+10, restart at N+11
    @(negedge clk); start = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    vseen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid) vseen++;
    end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_idle", {31'd0, busy}, 32'd0);
    run(3'd5, 32'd100, 32'd3, 0, "divu_after_flush");
    chk("flush_novalid", 32'(vseen), 32'd0);
    run(3'd7, 32'd100, 32'd3, 0, "remu");
    // start together with flush in IDLE
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
    #1 chk("flush_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    vseen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid || busy) vseen++;
    end
    chk("flush_start_ignored", 32'(vseen), 32'd0);
    // reset mid-operation
    @(negedge clk); start = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; rst_n = 1'b0;
    #1 chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    vseen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid) vseen++;
    end
    chk("arst_novalid", 32'(vseen), 32'd0);
    run(3'd1, 32'hFFFF_FFFF, 32'd5, 0, "after_reset");
    run(3'd4, 32'd1000, 32'hFFFF_FFF9, 5, "start_in_calc");
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      logic [31:0] b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      run(3'($urandom), a, b, 0, "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
